// File: rtl/fm_mem_model_if.sv
// Request/response bundle between the cache benches (master) and the
// shared far-memory model (slave).
interface fm_mem_model_if #(
    parameter int NUM_CH          = 2,
    parameter int ADRS_WIDTH      = 32,
    parameter int CL_WIDTH        = 128,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH*2-1:0]          req_opcode;
    logic [NUM_CH*ADRS_WIDTH-1:0] req_address;
    logic [NUM_CH*CL_WIDTH-1:0]   req_data;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH-1:0]            rsp_valid;
    logic [ADRS_WIDTH-1:0]        rsp_address;
    logic [CL_WIDTH-1:0]          rsp_data;
    logic [OUT_WIDTH-1:0]         outstanding;
    logic                         opcode_err;

    modport master (
        output req_valid, req_opcode, req_address, req_data,
        input  req_ready, rsp_valid, rsp_address, rsp_data, outstanding, opcode_err
    );

    modport slave (
        input  req_valid, req_opcode, req_address, req_data,
        output req_ready, rsp_valid, rsp_address, rsp_data, outstanding, opcode_err
    );
endinterface

// File: rtl/fm_mem_model.sv
// Multi-channel far-memory model: round-robin arbitrated line array serving
// evict writes and fixed-latency fill reads with an in-flight fill cap.
module fm_mem_model #(
    parameter int         NUM_CH          = 2,
    parameter int         ADRS_WIDTH      = 32,
    parameter int         OFFSET_WIDTH    = 4,
    parameter int         LINE_ADRS_WIDTH = 12,
    parameter int         CL_WIDTH        = 128,
    parameter int         LATENCY         = 12,
    parameter int         MAX_OUTSTANDING = 8,
    parameter logic [1:0] FILL_OP         = 2'b01,
    parameter logic [1:0] EVICT_OP        = 2'b10
) (
    input  logic          clk,
    input  logic          rst,
    fm_mem_model_if.slave bus
);
    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH     = 2 ** LINE_ADRS_WIDTH;

    logic [CL_WIDTH-1:0]        line_array [DEPTH];
    logic [PTR_WIDTH-1:0]       rr_ptr;
    logic [OUT_WIDTH-1:0]       outstanding;
    logic                       opcode_err;

    logic [NUM_CH-1:0]          eligible;
    logic [NUM_CH-1:0]          grant;
    logic [PTR_WIDTH-1:0]       grant_idx;
    logic [1:0]                 grant_op;
    logic [ADRS_WIDTH-1:0]      grant_address;
    logic [CL_WIDTH-1:0]        grant_data;
    logic [LINE_ADRS_WIDTH-1:0] grant_index;
    logic                       accept;
    logic                       fill_accept;
    logic                       evict_accept;
    logic                       illegal_accept;
    logic                       fill_full;
    logic                       pipe_exit;

    logic                       pipe_valid   [LATENCY];
    logic [NUM_CH-1:0]          pipe_ch      [LATENCY];
    logic [ADRS_WIDTH-1:0]      pipe_address [LATENCY];
    logic [CL_WIDTH-1:0]        pipe_data    [LATENCY];

    assign fill_full = (outstanding == OUT_WIDTH'(MAX_OUTSTANDING));

    // Only fills are held back by the cap; evicts and illegal opcodes always drain.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = bus.req_valid[c] &&
                          !(fill_full && (bus.req_opcode[2*c +: 2] == FILL_OP));
        end
    end

    always_comb begin : arbiter
        int cand;
        cand          = 0;
        grant         = '0;
        grant_idx     = '0;
        grant_op      = '0;
        grant_address = '0;
        grant_data    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if ((grant == '0) && eligible[cand] && !rst) begin
                grant[cand]   = 1'b1;
                grant_idx     = PTR_WIDTH'(cand);
                grant_op      = bus.req_opcode[2*cand +: 2];
                grant_address = bus.req_address[ADRS_WIDTH*cand +: ADRS_WIDTH];
                grant_data    = bus.req_data[CL_WIDTH*cand +: CL_WIDTH];
            end
        end
    end

    assign accept         = |grant;
    assign fill_accept    = accept && (grant_op == FILL_OP);
    assign evict_accept   = accept && (grant_op == EVICT_OP);
    assign illegal_accept = accept && (grant_op != FILL_OP) && (grant_op != EVICT_OP);
    assign grant_index    = grant_address[OFFSET_WIDTH +: LINE_ADRS_WIDTH];
    assign pipe_exit      = pipe_valid[LATENCY-1];

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (evict_accept) begin
            line_array[grant_index] <= grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            outstanding <= '0;
            opcode_err  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (grant_idx == PTR_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (fill_accept && !pipe_exit) begin
                outstanding <= outstanding + 1'b1;
            end else if (!fill_accept && pipe_exit) begin
                outstanding <= outstanding - 1'b1;
            end
            if (illegal_accept) begin
                opcode_err <= 1'b1;
            end
        end
    end

    // Idle stages carry zeros so the shared response bus reads 0 between fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_valid[s]   <= 1'b0;
                pipe_ch[s]      <= '0;
                pipe_address[s] <= '0;
                pipe_data[s]    <= '0;
            end
        end else begin
            pipe_valid[0]   <= fill_accept;
            pipe_ch[0]      <= fill_accept ? grant : '0;
            pipe_address[0] <= fill_accept ? grant_address : '0;
            pipe_data[0]    <= fill_accept ? line_array[grant_index] : '0;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid[s]   <= pipe_valid[s-1];
                pipe_ch[s]      <= pipe_ch[s-1];
                pipe_address[s] <= pipe_address[s-1];
                pipe_data[s]    <= pipe_data[s-1];
            end
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = pipe_valid[LATENCY-1] ? pipe_ch[LATENCY-1] : '0;
    assign bus.rsp_address = pipe_address[LATENCY-1];
    assign bus.rsp_data    = pipe_data[LATENCY-1];
    assign bus.outstanding = outstanding;
    assign bus.opcode_err  = opcode_err;
endmodule

// File: tb/tb_fm_mem_model.sv
// Self-checking bench for fm_mem_model: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fm_mem_model;
    localparam int         NUM_CH          = 2;
    localparam int         ADRS_WIDTH      = 32;
    localparam int         OFFSET_WIDTH    = 4;
    localparam int         LINE_ADRS_WIDTH = 4;
    localparam int         CL_WIDTH        = 64;
    localparam int         LATENCY         = 6;
    localparam int         MAX_OUTSTANDING = 3;
    localparam logic [1:0] FILL_OP         = 2'b01;
    localparam logic [1:0] EVICT_OP        = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fm_mem_model_if #(
        .NUM_CH(NUM_CH), .ADRS_WIDTH(ADRS_WIDTH),
        .CL_WIDTH(CL_WIDTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) bus ();

    fm_mem_model #(
        .NUM_CH(NUM_CH), .ADRS_WIDTH(ADRS_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH),
        .LINE_ADRS_WIDTH(LINE_ADRS_WIDTH), .CL_WIDTH(CL_WIDTH), .LATENCY(LATENCY),
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .FILL_OP(FILL_OP), .EVICT_OP(EVICT_OP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int                    due;
        int                    ch;
        logic [ADRS_WIDTH-1:0] address;
        logic [CL_WIDTH-1:0]   data;
    } fill_t;

    fill_t               pending[$];
    logic [CL_WIDTH-1:0] mem_model [2**LINE_ADRS_WIDTH];
    int                  model_rr;
    logic                model_err;
    int                  edge_no;
    bit                  checking;
    bit                  just_reset;
    int                  checks;
    int                  failures;
    int                  max_seen;

    logic                  drv_rst;
    logic [NUM_CH-1:0]     drv_valid;
    logic [1:0]            drv_op   [NUM_CH];
    logic [ADRS_WIDTH-1:0] drv_addr [NUM_CH];
    logic [CL_WIDTH-1:0]   drv_data [NUM_CH];

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)",
                     tag, observed, expected, edge_no);
        end
    endtask

    task automatic clearInputs();
        drv_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drv_op[c]   = 2'b00;
            drv_addr[c] = '0;
            drv_data[c] = '0;
        end
    endtask

    task automatic setChannel(input int c, input logic [1:0] op,
                              input logic [ADRS_WIDTH-1:0] addr, input logic [CL_WIDTH-1:0] data);
        drv_valid[c] = 1'b1;
        drv_op[c]    = op;
        drv_addr[c]  = addr;
        drv_data[c]  = data;
    endtask

    // One clock: check current outputs, drive inputs, check the grant, then
    // advance the reference model across the rising edge.
    task automatic applyStimulus();
        int                       gch;
        int                       cand;
        logic [NUM_CH-1:0]        exp_valid;
        logic [NUM_CH-1:0]        exp_ready;
        logic [LINE_ADRS_WIDTH-1:0] idx;
        fill_t                    entry;
        @(negedge clk);
        if (checking) begin
            exp_valid = '0;
            if ((pending.size() > 0) && (pending[0].due == edge_no)) begin
                exp_valid[pending[0].ch] = 1'b1;
                checkOutput("rsp_address", bus.rsp_address, pending[0].address);
                checkOutput("rsp_data", bus.rsp_data, pending[0].data);
            end else if (just_reset) begin
                checkOutput("rsp_address_reset", bus.rsp_address, '0);
                checkOutput("rsp_data_reset", bus.rsp_data, '0);
            end
            checkOutput("rsp_valid", bus.rsp_valid, exp_valid);
            checkOutput("outstanding", bus.outstanding, pending.size());
            checkOutput("opcode_err", bus.opcode_err, model_err);
            if (int'(bus.outstanding) > max_seen) max_seen = int'(bus.outstanding);
        end
        rst           = drv_rst;
        bus.req_valid = drv_valid;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.req_opcode[2*c +: 2]                    = drv_op[c];
            bus.req_address[ADRS_WIDTH*c +: ADRS_WIDTH] = drv_addr[c];
            bus.req_data[CL_WIDTH*c +: CL_WIDTH]        = drv_data[c];
        end
        #1;
        gch = -1;
        if (!drv_rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand = (model_rr + k) % NUM_CH;
                if ((gch < 0) && drv_valid[cand] &&
                    !((drv_op[cand] == FILL_OP) && (pending.size() == MAX_OUTSTANDING))) begin
                    gch = cand;
                end
            end
        end
        exp_ready = '0;
        if (gch >= 0) exp_ready[gch] = 1'b1;
        if (checking) checkOutput("req_ready", bus.req_ready, exp_ready);
        @(posedge clk);
        edge_no++;
        if (drv_rst) begin
            pending.delete();
            model_rr   = 0;
            model_err  = 1'b0;
            checking   = 1'b1;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if ((pending.size() > 0) && (pending[0].due == edge_no - 1)) begin
                void'(pending.pop_front());
            end
            if (gch >= 0) begin
                model_rr = (gch + 1) % NUM_CH;
                idx      = drv_addr[gch][OFFSET_WIDTH +: LINE_ADRS_WIDTH];
                if (drv_op[gch] == EVICT_OP) begin
                    mem_model[idx] = drv_data[gch];
                end else if (drv_op[gch] == FILL_OP) begin
                    entry.due     = edge_no + LATENCY - 1;
                    entry.ch      = gch;
                    entry.address = drv_addr[gch];
                    entry.data    = mem_model[idx];
                    pending.push_back(entry);
                end else begin
                    model_err = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        clearInputs();
        repeat (n) applyStimulus();
    endtask

    initial begin
        int r;
        checks     = 0;
        failures   = 0;
        max_seen   = 0;
        edge_no    = 0;
        model_rr   = 0;
        model_err  = 1'b0;
        checking   = 1'b0;
        just_reset = 1'b0;
        rst        = 1'b1;
        bus.req_valid   = '0;
        bus.req_opcode  = '0;
        bus.req_address = '0;
        bus.req_data    = '0;
        clearInputs();
        drv_rst = 1'b1;
        applyStimulus();
        applyStimulus();
        drv_rst = 1'b0;

        // Give every line a known value before any fill reads it.
        for (int i = 0; i < 2**LINE_ADRS_WIDTH; i++) begin
            clearInputs();
            setChannel(0, EVICT_OP, 32'h0000_0100 | (i << OFFSET_WIDTH), {$urandom, $urandom});
            applyStimulus();
        end
        idle(1);

        clearInputs();
        setChannel(0, EVICT_OP, 32'h0000_1230, {8{8'hA5}});
        applyStimulus();
        clearInputs();
        setChannel(0, FILL_OP, 32'h0000_1238, '0);
        applyStimulus();
        idle(LATENCY + 2);

        clearInputs();
        setChannel(0, FILL_OP, 32'h0000_0010, '0);
        setChannel(1, FILL_OP, 32'h0000_0020, '0);
        repeat (6) applyStimulus();
        idle(LATENCY + 2);

        for (int i = 0; i < 10; i++) begin
            clearInputs();
            setChannel(0, FILL_OP, 32'h0000_2000 | (i << OFFSET_WIDTH), '0);
            applyStimulus();
        end
        idle(LATENCY + 2);

        // Evict-then-fill sees new data; fill-then-evict sees old data.
        clearInputs();
        setChannel(0, EVICT_OP, 32'h0000_0050, 64'h1111_2222_3333_4444);
        applyStimulus();
        clearInputs();
        setChannel(1, FILL_OP, 32'h0000_0058, '0);
        applyStimulus();
        clearInputs();
        setChannel(1, FILL_OP, 32'h0000_0060, '0);
        applyStimulus();
        clearInputs();
        setChannel(0, EVICT_OP, 32'h0000_0060, 64'h5555_6666_7777_8888);
        applyStimulus();
        idle(LATENCY + 2);

        clearInputs();
        setChannel(1, 2'b11, 32'h0000_0070, 64'hDEAD_BEEF_DEAD_BEEF);
        applyStimulus();
        clearInputs();
        setChannel(0, FILL_OP, 32'h0000_0070, '0);
        applyStimulus();
        idle(LATENCY + 2);

        clearInputs();
        setChannel(0, EVICT_OP, 32'h0000_0080, 64'hCAFE_F00D_0123_4567);
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            setChannel(0, FILL_OP, 32'h0000_0090 + (i << OFFSET_WIDTH), '0);
            applyStimulus();
        end
        clearInputs();
        drv_rst = 1'b1;
        applyStimulus();
        drv_rst = 1'b0;
        idle(LATENCY + 2);
        setChannel(0, FILL_OP, 32'h0000_0088, '0);
        applyStimulus();
        idle(LATENCY + 2);

        for (int n = 0; n < 400; n++) begin
            clearInputs();
            drv_rst = ($urandom_range(0, 149) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 19);
                    setChannel(c, (r < 9) ? FILL_OP : (r < 18) ? EVICT_OP : (r == 18) ? 2'b00 : 2'b11,
                               $urandom, {$urandom, $urandom});
                end
            end
            applyStimulus();
        end
        drv_rst = 1'b0;
        idle(LATENCY + 2);

        checkOutput("max_outstanding_bound", (max_seen <= MAX_OUTSTANDING), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fm_mem_model.md
# fm_mem_model

Parametrised multi-channel far-memory model for the mem_ss cache benches. It serves cache-line fill reads and dirty-evict writes from up to NUM_CH cache instances (d_cache, i_cache, …) through one shared line array. Requests are round-robin arbitrated and fills are returned on the requesting channel after a configurable fixed latency, with an outstanding-fill cap. It replaces the fixed 12-cycle array-plus-shift-register far memory wired directly into a single DUT.

## Interface
- NUM_CH, 2: number of request/response channels (1..8)
- ADRS_WIDTH, 32: byte address width
- OFFSET_WIDTH, 4: line-offset bits, ignored for indexing
- LINE_ADRS_WIDTH, 12: line index bits; array depth 2^LINE_ADRS_WIDTH
- CL_WIDTH, 128: cache-line width
- LATENCY, 12: accept-to-response cycles (min 1)
- MAX_OUTSTANDING, 8: max in-flight fills (1..LATENCY)
- FILL_OP, 2'b01 / EVICT_OP, 2'b10: opcode encodings, matching FILL_REQ_OP / DIRTY_EVICT_OP

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NUM_CH  per-channel request valid
- req_opcode  in  NUM_CH*2  per-channel opcode
- req_address  in  NUM_CH*ADRS_WIDTH  per-channel byte address
- req_data  in  NUM_CH*CL_WIDTH  per-channel evict data
- req_ready  out  NUM_CH  one-hot grant; accept = valid & ready
- rsp_valid  out  NUM_CH  per-channel fill response valid
- rsp_address  out  ADRS_WIDTH  address of returned fill (shared bus)
- rsp_data  out  CL_WIDTH  returned line (shared bus)
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight fill count
- opcode_err  out  1  sticky, set on an accepted illegal opcode

## Operation
- Arbitration: combinational round-robin over req_valid, starting at rr_ptr. At most one req_ready bit high per cycle, and only toward a valid channel.
- FILL candidates are masked while outstanding == MAX_OUTSTANDING. EVICT and illegal opcodes are never masked.
- rr_ptr advances to granted channel + 1 (mod NUM_CH) on accept. It is unchanged if nothing is accepted.
- Index = address[OFFSET_WIDTH +: LINE_ADRS_WIDTH].
- EVICT accept: array[index] <= data at that edge. No response.
- FILL accept: array[index] is read in the accept cycle. Channel id, address and data enter a LATENCY-deep pipeline.
- Because only one accept happens per cycle, a fill always sees all prior evicts.
- Illegal opcode (00/11) accept: consumed, no array or pipeline effect, opcode_err <= 1.
- outstanding: +1 on fill accept, −1 on pipeline exit, unchanged when both happen in the same cycle.
- Responses have no backpressure. Consumers must always accept.

## Timing
- Fill accepted at edge T: rsp_valid[ch] is high for exactly one cycle, between edges T+LATENCY-1 and T+LATENCY. rsp_address/rsp_data are valid in that cycle only.
- Back-to-back fills produce back-to-back responses, in order. Only one rsp_valid bit is high per cycle.
- Evict write is visible to a fill accepted at T+1 or later.
- Reset values: rsp_valid=0, rsp_address=0, rsp_data=0, outstanding=0, opcode_err=0, rr_ptr=0, pipeline valids cleared.
- Reset values drive req_ready=0 during rst.
- Array contents are not reset.
- Reset mid-operation drops all in-flight fills with no late responses. Array writes already committed are retained.
- MAX_OUTSTANDING reached: fills stall (ready low) until a response exits. In the cycle a response exits, the counter is still at max, so a new fill is granted one cycle later.

## Test plan
- Single channel, EVICT 0x0000_1230 data 0xA5…A5, then FILL 0x0000_1238 -> rsp_valid[0] exactly LATENCY cycles after fill accept, rsp_data 0xA5…A5, rsp_address 0x0000_1238.
- Both channels assert FILL every cycle for 6 cycles -> grants alternate ch0,ch1,ch0…, responses return in the same order at LATENCY spacing, and each rsp_valid bit is one-hot to its requester.
- MAX_OUTSTANDING=2, LATENCY=12, ch0 streams 4 fills -> 2 accepted, ready low until first response, outstanding never exceeds 2, total 4 correct responses.
- EVICT then FILL to same line on consecutive cycles from different channels -> fill returns the new data. Fill one cycle before the evict returns the old data.
- Opcode 2'b11 on ch1 -> accepted, no response, array unchanged, opcode_err=1 and held until rst.
- Assert rst for 1 cycle with 3 fills in flight -> no rsp_valid afterwards, outstanding=0, a post-reset FILL returns pre-reset evicted data.
